// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Raster timing bundle from vga_timing_gen to the colour mapper
//               and game logic.
//               master : driven by the timing generator
//               slave  : consumed by colour mapper / game logic
//   DrawX       [9:0]  current horizontal count
//   DrawY       [9:0]  current vertical count
//   blank              1 = active video, 0 = blanking
//   frame_clk          1 during vertical blanking (rising edge = frame end)
//   line_start         single-cycle pulse when DrawX == 0
//   hs / vs            active-low syncs, aligned with registered RGB
//   frame_count [15:0] completed-frame counter
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        frame_clk;
    logic        line_start;
    logic        hs;
    logic        vs;
    logic [15:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, frame_clk, line_start, hs, vs, frame_count
    );

    modport slave (
        input  DrawX, DrawY, blank, frame_clk, line_start, hs, vs, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Pixel-rate raster timing generator (640x480@60 by default).
//               Horizontal/vertical counters, registered decode flags,
//               sync delay pipe matching downstream RGB latency and a
//               completed-frame counter.
// Ports       : pixel_clk  - pixel clock, sole clock
//               Reset_n    - asynchronous assert, active-low reset
//               vga        - vga_timing_gen_if.master timing outputs
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int RGB_LAT = 1
) (
    input  wire logic          pixel_clk,
    input  wire logic          Reset_n,
    vga_timing_gen_if.master   vga
);

    localparam int         c_H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int         c_V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);

    // Decode bounds are one bit wider so a sync end landing exactly on 1024
    // still compares correctly against the zero-extended counters.
    localparam logic [10:0] c_H_VIS      = 11'(H_VIS);
    localparam logic [10:0] c_HS_START   = 11'(H_VIS + H_FP);
    localparam logic [10:0] c_HS_END     = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] c_V_VIS      = 11'(V_VIS);
    localparam logic [10:0] c_VS_START   = 11'(V_VIS + V_FP);
    localparam logic [10:0] c_VS_END     = 11'(V_VIS + V_FP + V_SYNC);

    logic [9:0]  r_draw_x;
    logic [9:0]  r_draw_y;
    logic        r_blank;
    logic        r_frame_clk;
    logic        r_line_start;
    logic        r_hsync_raw;
    logic        r_vsync_raw;
    logic [15:0] r_frame_count;

    logic        w_x_wrap;
    logic        w_y_wrap;
    logic [9:0]  w_x_next;
    logic [9:0]  w_y_next;
    logic [10:0] w_x_ext;
    logic [10:0] w_y_ext;
    logic        w_hs;
    logic        w_vs;

    // Next-state counters. Flags are decoded from these so the registered
    // flags describe the same pixel as the registered counters.
    always_comb begin
        w_x_wrap = (r_draw_x == c_H_LAST);
        w_y_wrap = (r_draw_y == c_V_LAST);
        w_x_next = w_x_wrap ? 10'd0 : r_draw_x + 10'd1;
        w_y_next = r_draw_y;
        if (w_x_wrap) begin
            w_y_next = w_y_wrap ? 10'd0 : r_draw_y + 10'd1;
        end
        w_x_ext  = {1'b0, w_x_next};
        w_y_ext  = {1'b0, w_y_next};
    end

    always_ff @(posedge pixel_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_draw_x      <= 10'd0;
            r_draw_y      <= 10'd0;
            r_blank       <= 1'b1;
            r_frame_clk   <= 1'b0;
            r_line_start  <= 1'b1;
            r_hsync_raw   <= 1'b1;
            r_vsync_raw   <= 1'b1;
            r_frame_count <= 16'd0;
        end else begin
            r_draw_x      <= w_x_next;
            r_draw_y      <= w_y_next;
            r_blank       <= (w_x_ext < c_H_VIS) && (w_y_ext < c_V_VIS);
            r_frame_clk   <= (w_y_ext >= c_V_VIS);
            r_line_start  <= (w_x_next == 10'd0);
            r_hsync_raw   <= !((w_x_ext >= c_HS_START) && (w_x_ext < c_HS_END));
            r_vsync_raw   <= !((w_y_ext >= c_VS_START) && (w_y_ext < c_VS_END));
            // A frame completes when both counters wrap together.
            if (w_x_wrap && w_y_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // Sync delay so hs/vs land at the DAC together with the registered RGB.
    generate
        if (RGB_LAT == 0) begin : g_no_delay
            assign w_hs = r_hsync_raw;
            assign w_vs = r_vsync_raw;
        end else begin : g_delay
            logic [RGB_LAT-1:0] r_hs_pipe;
            logic [RGB_LAT-1:0] r_vs_pipe;

            always_ff @(posedge pixel_clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_hs_pipe <= '1;
                    r_vs_pipe <= '1;
                end else begin
                    r_hs_pipe[0] <= r_hsync_raw;
                    r_vs_pipe[0] <= r_vsync_raw;
                    for (int i = 1; i < RGB_LAT; i++) begin
                        r_hs_pipe[i] <= r_hs_pipe[i-1];
                        r_vs_pipe[i] <= r_vs_pipe[i-1];
                    end
                end
            end

            assign w_hs = r_hs_pipe[RGB_LAT-1];
            assign w_vs = r_vs_pipe[RGB_LAT-1];
        end
    endgenerate

    assign vga.DrawX       = r_draw_x;
    assign vga.DrawY       = r_draw_y;
    assign vga.blank       = r_blank;
    assign vga.frame_clk   = r_frame_clk;
    assign vga.line_start  = r_line_start;
    assign vga.hs          = w_hs;
    assign vga.vs          = w_vs;
    assign vga.frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed testbench for vga_timing_gen. A default-geometry
//               instance checks line-level timing; RGB_LAT=0 and RGB_LAT=3
//               instances check the sync delay; a reduced-geometry instance
//               (24 x 17, frame = 408 cycles) checks vertical sync, frame
//               boundaries, mid-frame reset and frame_count wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic pixel_clk;
    logic Reset_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    vga_timing_gen_if vga_def ();
    vga_timing_gen_if vga_l0  ();
    vga_timing_gen_if vga_l3  ();
    vga_timing_gen_if vga_sm  ();

    vga_timing_gen u_def (
        .pixel_clk (pixel_clk),
        .Reset_n   (Reset_n),
        .vga       (vga_def)
    );

    vga_timing_gen #(.RGB_LAT(0)) u_l0 (
        .pixel_clk (pixel_clk),
        .Reset_n   (Reset_n),
        .vga       (vga_l0)
    );

    vga_timing_gen #(.RGB_LAT(3)) u_l3 (
        .pixel_clk (pixel_clk),
        .Reset_n   (Reset_n),
        .vga       (vga_l3)
    );

    // 16+2+4+2 = 24 pixels per line, 10+2+2+3 = 17 lines, 408 cycles/frame.
    vga_timing_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .RGB_LAT(1)
    ) u_sm (
        .pixel_clk (pixel_clk),
        .Reset_n   (Reset_n),
        .vga       (vga_sm)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    // Cycle index relative to the last reset release: cycle n is the value
    // seen after n rising edges, so DrawX == n on the first line.
    always @(posedge pixel_clk or negedge Reset_n) begin
        if (!Reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 5000) begin
            @(negedge pixel_clk);
            guard++;
        end
        #1;
        if (cyc != n) check_val("timeout", cyc, n);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        Reset_n = 1'b0;
        repeat (3) @(negedge pixel_clk);
        Reset_n = 1'b1;
        #1;

        // Cycle 0: reset values
        check_val("def_x0",     vga_def.DrawX, 0);
        check_val("def_y0",     vga_def.DrawY, 0);
        check_val("def_blank0", vga_def.blank, 1);
        check_val("def_ls0",    vga_def.line_start, 1);
        check_val("def_fclk0",  vga_def.frame_clk, 0);
        check_val("def_hs0",    vga_def.hs, 1);
        check_val("def_vs0",    vga_def.vs, 1);
        check_val("def_fc0",    vga_def.frame_count, 0);
        check_val("l0_hs0",     vga_l0.hs, 1);
        check_val("l3_hs0",     vga_l3.hs, 1);

        wait_cyc(1);
        check_val("def_x1",  vga_def.DrawX, 1);
        check_val("def_ls1", vga_def.line_start, 0);

        // Small geometry: raw hsync low at x=18..21, delayed by 1
        wait_cyc(18);  check_val("sm_hs18", vga_sm.hs, 1);
        wait_cyc(19);  check_val("sm_hs19", vga_sm.hs, 0);
        wait_cyc(22);  check_val("sm_hs22", vga_sm.hs, 0);
        wait_cyc(23);  check_val("sm_hs23", vga_sm.hs, 1);

        // Vertical blanking begins at line 10 = cycle 240
        wait_cyc(239); check_val("sm_fclk239", vga_sm.frame_clk, 0);
        wait_cyc(240);
        check_val("sm_fclk240",  vga_sm.frame_clk, 1);
        check_val("sm_blank240", vga_sm.blank, 0);
        wait_cyc(250); check_val("sm_blank250", vga_sm.blank, 0);

        // Raw vsync low on lines 12..13 = cycles 288..335, delayed by 1
        wait_cyc(288); check_val("sm_vs288", vga_sm.vs, 1);
        wait_cyc(289); check_val("sm_vs289", vga_sm.vs, 0);
        wait_cyc(336); check_val("sm_vs336", vga_sm.vs, 0);
        wait_cyc(337); check_val("sm_vs337", vga_sm.vs, 1);

        wait_cyc(407);
        check_val("sm_fc407", vga_sm.frame_count, 0);
        check_val("sm_x407",  vga_sm.DrawX, 23);
        check_val("sm_y407",  vga_sm.DrawY, 16);
        wait_cyc(408);
        check_val("sm_fc408",   vga_sm.frame_count, 1);
        check_val("sm_fclk408", vga_sm.frame_clk, 0);
        check_val("sm_x408",    vga_sm.DrawX, 0);
        check_val("sm_y408",    vga_sm.DrawY, 0);
        check_val("sm_ls408",   vga_sm.line_start, 1);

        // Default geometry line timing
        wait_cyc(639); check_val("def_blank639", vga_def.blank, 1);
        wait_cyc(640); check_val("def_blank640", vga_def.blank, 0);
        wait_cyc(655); check_val("l0_hs655", vga_l0.hs, 1);
        wait_cyc(656);
        check_val("l0_hs656",  vga_l0.hs, 0);
        check_val("def_hs656", vga_def.hs, 1);
        wait_cyc(657); check_val("def_hs657", vga_def.hs, 0);
        wait_cyc(658); check_val("l3_hs658",  vga_l3.hs, 1);
        wait_cyc(659); check_val("l3_hs659",  vga_l3.hs, 0);
        wait_cyc(752); check_val("def_hs752", vga_def.hs, 0);
        wait_cyc(753); check_val("def_hs753", vga_def.hs, 1);
        wait_cyc(799); check_val("def_x799",  vga_def.DrawX, 799);
        wait_cyc(800);
        check_val("def_x800",  vga_def.DrawX, 0);
        check_val("def_y800",  vga_def.DrawY, 1);
        check_val("def_ls800", vga_def.line_start, 1);
        wait_cyc(816); check_val("sm_fc816", vga_sm.frame_count, 2);
        wait_cyc(1456); check_val("def_hs1456", vga_def.hs, 1);
        wait_cyc(1457); check_val("def_hs1457", vga_def.hs, 0);

        // Mid-frame reset on small instance at (20,6) of frame 4
        wait_cyc(1796);
        check_val("pre_x",  vga_sm.DrawX, 20);
        check_val("pre_y",  vga_sm.DrawY, 6);
        check_val("pre_hs", vga_sm.hs, 0);
        check_val("pre_fc", vga_sm.frame_count, 4);
        Reset_n = 1'b0;
        #1;
        check_val("rst_x",     vga_sm.DrawX, 0);
        check_val("rst_y",     vga_sm.DrawY, 0);
        check_val("rst_hs",    vga_sm.hs, 1);
        check_val("rst_blank", vga_sm.blank, 1);
        check_val("rst_ls",    vga_sm.line_start, 1);
        check_val("rst_fc",    vga_sm.frame_count, 0);
        check_val("rst_def_y", vga_def.DrawY, 0);
        repeat (2) @(negedge pixel_clk);
        Reset_n = 1'b1;
        #1;
        check_val("rel_x0", vga_sm.DrawX, 0);
        wait_cyc(3);
        check_val("rel_x3", vga_sm.DrawX, 3);
        check_val("rel_fc", vga_sm.frame_count, 0);

        // frame_count wrap from 16'hFFFF
        wait_cyc(10);
        force u_sm.r_frame_count = 16'hFFFF;
        #1;
        release u_sm.r_frame_count;
        wait_cyc(407); check_val("wrap_pre",  vga_sm.frame_count, 32'hFFFF);
        wait_cyc(408); check_val("wrap_post", vga_sm.frame_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-rate raster timing generator for the 640x480@60 display path. It runs horizontal and vertical counters on `pixel_clk` and produces `DrawX`/`DrawY`, the `blank` active-video flag and `frame_clk`, which the color mapper and game logic consume. It also produces `hs`/`vs` syncs delayed to line up with the color mapper's registered `Red`/`Green`/`Blue` at the DAC, plus a frame counter for game timing.

## Interface
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels); H_TOTAL = sum of the four H parameters = 800
- `V_VIS`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines); V_TOTAL = 525
- `RGB_LAT`, 1, pixel_clk cycles of downstream colour latency that `hs`/`vs` must match (0..3)
- `pixel_clk  in  1  pixel clock (25 MHz nominal); sole clock`
- `Reset_n  in  1  asynchronous, active-low reset`
- `DrawX  out  10  current horizontal count, 0..H_TOTAL-1`
- `DrawY  out  10  current vertical count, 0..V_TOTAL-1`
- `blank  out  1  1 = active video (DrawX<H_VIS and DrawY<V_VIS); 0 = blanking`
- `frame_clk  out  1  1 while DrawY>=V_VIS (vertical blanking); rising edge marks frame end`
- `line_start  out  1  single-cycle pulse when DrawX==0`
- `hs  out  1  horizontal sync, active-low, delayed RGB_LAT cycles`
- `vs  out  1  vertical sync, active-low, delayed RGB_LAT cycles`
- `frame_count  out  16  completed-frame counter, wraps at 16'hFFFF`

## Operation
- Reset (asynchronous assert on Reset_n low; synchronous release):
  - DrawX = DrawY = 0; blank = 1; frame_clk = 0; line_start = 1.
  - hs = vs = 1; all delay-pipe stages = 1.
  - frame_count = 0.
- Horizontal counter:
  - DrawX increments by 1 every cycle.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - DrawY increments only on a cycle where DrawX wraps.
  - At V_TOTAL-1 it wraps to 0 on the same cycle that DrawX wraps.
- Decoded flags are registered, computed from the next-state counter values, so they are valid in the same cycle as the DrawX/DrawY they describe:
  - blank, frame_clk and line_start follow the definitions in Interface.
  - Raw hsync = 0 when H_VIS+H_FP <= DrawX < H_VIS+H_FP+H_SYNC (656..751).
  - Raw vsync = 0 when V_VIS+V_FP <= DrawY < V_VIS+V_FP+V_SYNC (490..491), for every pixel of those lines.
- Sync delay:
  - Raw hsync/vsync pass through an RGB_LAT-deep shift register to form hs/vs.
  - RGB_LAT = 0 means hs/vs equal the raw syncs.
- frame_count increments by 1 on the cycle where DrawY and DrawX both wrap to 0, and wraps modulo 2^16.
- Counter widths are 10 bits; every parameter sum must be <= 1024.
- Reset mid-frame restarts at (0,0) immediately. No partial-frame completion is counted.

## Timing
- Cycle counting starts at cycle 0, the first pixel_clk edge after Reset_n release; DrawX = 0 on that cycle.
- Line period is 800 cycles. Frame period is 420000 cycles.
- DrawX/DrawY/blank/frame_clk/line_start have zero latency relative to each other, all registered.
- hs/vs lag DrawX/DrawY by exactly RGB_LAT cycles. The color mapper registers RGB once, so the default is 1.
- frame_clk rises at cycle 480*800 = 384000 and falls at cycle 420000, when the count returns to (0,0).
- All outputs are glitch-free register outputs. No combinational paths from inputs to outputs.

## Test plan
- Reset release, default parameters → cycle 0: DrawX=0, DrawY=0, blank=1, line_start=1; cycle 639: blank=1; cycle 640: blank=0; cycle 800: DrawX=0, DrawY=1, line_start=1.
- Horizontal sync, RGB_LAT=1 → hs falls at cycle 657, rises at cycle 753; repeats every 800 cycles.
- Vertical sync, RGB_LAT=1 → vs low from cycle 490*800+1 = 392001 through cycle 393600 (1600 cycles); high elsewhere.
- Frame boundary → frame_clk rises at cycle 384000 and falls at 420000; frame_count goes 0→1 at cycle 420000 and 1→2 at 840000; blank stays 0 throughout lines 480..524.
- Reset mid-frame: assert Reset_n=0 at DrawX=300, DrawY=200 without a clock edge → outputs go to reset values asynchronously; after release, sequence restarts at (0,0) and frame_count=0.
- Wrap and parameter checks: preload frame_count=16'hFFFF via hierarchical force, run one frame → frame_count=0. With RGB_LAT=0, hs falls at cycle 656. With RGB_LAT=3, hs falls at cycle 659.
